// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier I/O sequencer.
package booth_pkg;

    // Default operand width; the product is twice this wide.
    localparam int BOOTH_W = 5;

    // Default number of WAIT cycles allowed before a transaction is abandoned.
    localparam int BOOTH_TIMEOUT = 64;

    // Sequencer states, in the order a normal transaction visits them.
    typedef enum logic [2:0] {
        IDLE,
        SEND_X,
        SEND_Y,
        WAIT,
        CAP_LO,
        RESP
    } state_t;

    // One buffered operand pair: multiplicand x and multiplier y.
    typedef struct packed {
        logic [BOOTH_W-1:0] x;
        logic [BOOTH_W-1:0] y;
    } pair_t;

endpackage

// File: rtl/op_pair_fifo.sv
// Small synchronous FIFO holding operand pairs until the sequencer issues them.
module op_pair_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_push,
    input  pair_t i_data,
    input  logic  i_pop,
    output pair_t o_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pair_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [CW-1:0]  r_count;
    logic           w_doPush;
    logic           w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/booth_seq_frontend.sv
// Feeds operand pairs to a sequential Booth multiplier over its shared bus and
// reassembles the two-beat product upload into a handshaked result, with a
// done-timeout so a hung multiplier cannot stall the datapath.
module booth_seq_frontend
    import booth_pkg::*;
#(
    parameter int W       = BOOTH_W,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = BOOTH_TIMEOUT
)(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_op_valid,
    output logic           o_op_ready,
    input  logic [W-1:0]   i_op_x,
    input  logic [W-1:0]   i_op_y,
    output logic [W-1:0]   o_mul_inbus,
    output logic           o_mul_start,
    input  logic [W-1:0]   i_mul_outbus,
    input  logic           i_mul_done,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic [2*W-1:0] o_res_prod,
    output logic           o_res_err,
    output logic           o_busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic            r_rdyEn;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_hi;
    logic [2*W-1:0]  r_prod;
    logic            r_err;
    logic [TW-1:0]   r_cnt;
    pair_t           w_pushData;
    pair_t           w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_timeout;

    assign w_pushData.x = i_op_x;
    assign w_pushData.y = i_op_y;
    assign o_op_ready   = r_rdyEn && !w_full;
    assign w_push       = i_op_valid && o_op_ready;
    assign w_pop        = (r_state == IDLE) && !w_empty;
    assign w_timeout    = (r_cnt == T_LAST);

    op_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Holds op_ready low through reset and lifts it on the first clock afterwards.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rdyEn <= 1'b0;
        end else begin
            r_rdyEn <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; done outside WAIT is ignored and done wins over timeout.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_nextState = SEND_X;
            SEND_X:  w_nextState = SEND_Y;
            SEND_Y:  w_nextState = WAIT;
            WAIT: begin
                if (i_mul_done) begin
                    w_nextState = CAP_LO;
                end else if (w_timeout) begin
                    w_nextState = RESP;
                end
            end
            CAP_LO:  w_nextState = RESP;
            RESP:    if (i_res_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Multiplier bus and status outputs decoded from the current state.
    always_comb begin
        o_mul_start = 1'b0;
        o_mul_inbus = '0;
        unique case (r_state)
            SEND_X: begin
                o_mul_start = 1'b1;
                o_mul_inbus = r_x;
            end
            SEND_Y:  o_mul_inbus = r_y;
            default: o_mul_inbus = '0;
        endcase
        o_res_valid = (r_state == RESP);
        o_res_err   = (r_state == RESP) && r_err;
        o_busy      = (r_state != IDLE);
        o_res_prod  = r_prod;
    end

    // Operand latch at pop, timeout counter and product/error capture.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_hi   <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_x <= w_head.x;
                r_y <= w_head.y;
            end
            case (r_state)
                SEND_Y: r_cnt <= '0;
                WAIT: begin
                    if (i_mul_done) begin
                        r_hi <= i_mul_outbus;
                    end else if (w_timeout) begin
                        r_prod <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                CAP_LO: begin
                    r_prod <= {r_hi, i_mul_outbus};
                    r_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_frontend.sv
// Self-checking bench for booth_seq_frontend with a behavioural multiplier model.
module tb_booth_seq_frontend;

   typedef struct {
      logic [4:0] x;
      logic [4:0] y;
      int         lat;
      logic [9:0] prod;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       opValid;
   logic       opReady;
   logic [4:0] opX;
   logic [4:0] opY;
   logic [4:0] mulInbus;
   logic       mulStart;
   logic [4:0] mulOutbus;
   logic       mulDone;
   logic       resValid;
   logic       resReady;
   logic [9:0] resProd;
   logic       resErr;
   logic       busy;

   int checks = 0;
   int errors = 0;

   vec_t opQ[$];
   vec_t resQ[$];
   vec_t vecs[9];
   vec_t bpVecs[3];

   int               modelPhase = 0;
   int               modelCnt = 0;
   vec_t             modelCur;
   logic signed [9:0] modelProd;
   logic signed [9:0] sx;
   logic signed [9:0] sy;
   logic             strayPulse = 1'b0;
   logic             sawStart;

   booth_seq_frontend #(
      .W       (5),
      .DEPTH   (2),
      .TIMEOUT (8)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_op_valid   (opValid),
      .o_op_ready   (opReady),
      .i_op_x       (opX),
      .i_op_y       (opY),
      .o_mul_inbus  (mulInbus),
      .o_mul_start  (mulStart),
      .i_mul_outbus (mulOutbus),
      .i_mul_done   (mulDone),
      .o_res_valid  (resValid),
      .i_res_ready  (resReady),
      .o_res_prod   (resProd),
      .o_res_err    (resErr),
      .o_busy       (busy)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: counted, and reported when actual differs from required.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // A bounded wait that expired, or an event that should never occur.
   task automatic noteFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=expired required=event", name);
   endtask

   // Behavioural multiplier: checks the X/Y bus protocol, then uploads hi and lo
   // after the programmed latency (lat<0 means it never answers).
   always @(negedge clk) begin
      mulDone   = 1'b0;
      mulOutbus = 5'd0;
      if (!rst) begin
         modelPhase = 0;
      end else begin
         case (modelPhase)
            0: begin
               if (mulStart) begin
                  if (opQ.size() == 0) begin
                     noteFail("unexpected_start");
                  end else begin
                     modelCur = opQ.pop_front();
                     checkOutput("mul_x", {27'd0, mulInbus}, {27'd0, modelCur.x});
                     sx = {{5{modelCur.x[4]}}, modelCur.x};
                     sy = {{5{modelCur.y[4]}}, modelCur.y};
                     modelProd = sx * sy;
                     modelPhase = 1;
                  end
               end else if (strayPulse) begin
                  mulDone    = 1'b1;
                  mulOutbus  = 5'h15;
                  strayPulse = 1'b0;
               end
            end
            1: begin
               checkOutput("start_one_cycle", {31'd0, mulStart}, 32'd0);
               checkOutput("mul_y", {27'd0, mulInbus}, {27'd0, modelCur.y});
               if (modelCur.lat < 0) begin
                  modelPhase = 0;
               end else begin
                  modelCnt   = modelCur.lat;
                  modelPhase = 2;
               end
            end
            2: begin
               if (modelCnt == 0) begin
                  mulDone    = 1'b1;
                  mulOutbus  = modelProd[9:5];
                  modelPhase = 3;
               end else begin
                  modelCnt--;
               end
            end
            default: begin
               mulOutbus  = modelProd[4:0];
               modelPhase = 0;
            end
         endcase
      end
   end

   // Scoreboard consumer: every result handshake pops and compares the oldest expectation.
   always @(negedge clk) begin
      if (rst && resValid && resReady) begin
         if (resQ.size() == 0) begin
            noteFail("unexpected_result");
         end else begin
            vec_t e;
            e = resQ.pop_front();
            checkOutput("res_prod", {22'd0, resProd}, {22'd0, e.prod});
            checkOutput("res_err", {31'd0, resErr}, {31'd0, e.err});
         end
      end
   end

   // Offers one operand pair, waiting a bounded time for op_ready.
   task automatic applyStimulus(input vec_t v);
      int n = 0;
      @(negedge clk);
      while (!opReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!opReady) begin
         noteFail("op_ready_wait");
      end else begin
         opValid = 1'b1;
         opX     = v.x;
         opY     = v.y;
         opQ.push_back(v);
         resQ.push_back(v);
         @(negedge clk);
         opValid = 1'b0;
      end
   endtask

   // Waits, bounded, until every expected result has been seen and the FSM is idle.
   task automatic waitIdle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((resQ.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) noteFail("drain_wait");
   endtask

   // Main sequence: reset, table vectors, backpressure, stray done, reset mid-WAIT.
   initial begin
      rst = 1'b1;
      opValid = 1'b0;
      opX = 5'd0;
      opY = 5'd0;
      resReady = 1'b0;

      vecs[0] = '{x: 5'd3,  y: 5'd7,  lat: 2,  prod: 10'h015, err: 1'b0};
      vecs[1] = '{x: 5'h1D, y: 5'd7,  lat: 0,  prod: 10'h3EB, err: 1'b0};
      vecs[2] = '{x: 5'h10, y: 5'h10, lat: 3,  prod: 10'h100, err: 1'b0};
      vecs[3] = '{x: 5'h0F, y: 5'h10, lat: 1,  prod: 10'h310, err: 1'b0};
      vecs[4] = '{x: 5'd0,  y: 5'h1F, lat: 0,  prod: 10'h000, err: 1'b0};
      vecs[5] = '{x: 5'd5,  y: 5'd5,  lat: 8,  prod: 10'h000, err: 1'b1};
      vecs[6] = '{x: 5'd6,  y: 5'h19, lat: 7,  prod: 10'h3D6, err: 1'b0};
      vecs[7] = '{x: 5'h1F, y: 5'h1F, lat: 0,  prod: 10'h001, err: 1'b0};
      vecs[8] = '{x: 5'd2,  y: 5'd3,  lat: -1, prod: 10'h000, err: 1'b1};

      bpVecs[0] = '{x: 5'd1,  y: 5'd2, lat: 1, prod: 10'h002, err: 1'b0};
      bpVecs[1] = '{x: 5'h1E, y: 5'd3, lat: 0, prod: 10'h3FA, err: 1'b0};
      bpVecs[2] = '{x: 5'd7,  y: 5'd7, lat: 2, prod: 10'h031, err: 1'b0};

      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_op_ready", {31'd0, opReady}, 32'd0);
      checkOutput("rst_res_valid", {31'd0, resValid}, 32'd0);
      checkOutput("rst_res_err", {31'd0, resErr}, 32'd0);
      checkOutput("rst_res_prod", {22'd0, resProd}, 32'd0);
      checkOutput("rst_mul_start", {31'd0, mulStart}, 32'd0);
      checkOutput("rst_mul_inbus", {27'd0, mulInbus}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("op_ready_after_release", {31'd0, opReady}, 32'd1);

      @(posedge clk);
      #1 resReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         waitIdle(300);
      end

      // Backpressure: one pair in flight held in RESP plus two buffered fills the FIFO.
      @(posedge clk);
      #1 resReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(bpVecs[i]);
      end
      repeat (3) @(negedge clk);
      checkOutput("bp_op_ready_full", {31'd0, opReady}, 32'd0);
      checkOutput("bp_res_valid", {31'd0, resValid}, 32'd1);
      checkOutput("bp_prod_held", {22'd0, resProd}, 32'h002);
      repeat (10) @(negedge clk);
      checkOutput("bp_prod_stable", {22'd0, resProd}, 32'h002);
      checkOutput("bp_still_full", {31'd0, opReady}, 32'd0);
      @(posedge clk);
      #1 resReady = 1'b1;
      waitIdle(400);

      // A done pulse while idle must not start anything.
      strayPulse = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("stray_done_busy", {31'd0, busy}, 32'd0);
      checkOutput("stray_done_valid", {31'd0, resValid}, 32'd0);

      // Reset while waiting on a hung multiplier with one more pair buffered.
      applyStimulus('{x: 5'd2, y: 5'd3, lat: -1, prod: 10'h000, err: 1'b1});
      begin
         int n = 0;
         while (!busy && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!busy) noteFail("busy_wait");
      end
      repeat (4) @(negedge clk);
      applyStimulus('{x: 5'd4, y: 5'd4, lat: 0, prod: 10'h010, err: 1'b0});
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_rst_start", {31'd0, mulStart}, 32'd0);
      checkOutput("async_rst_inbus", {27'd0, mulInbus}, 32'd0);
      checkOutput("async_rst_valid", {31'd0, resValid}, 32'd0);
      checkOutput("async_rst_op_ready", {31'd0, opReady}, 32'd0);
      checkOutput("async_rst_prod", {22'd0, resProd}, 32'd0);
      opQ.delete();
      resQ.delete();
      @(negedge clk);
      rst = 1'b1;
      sawStart = 1'b0;
      repeat (10) begin
         @(negedge clk);
         sawStart = sawStart | mulStart;
      end
      checkOutput("no_start_after_reset", {31'd0, sawStart}, 32'd0);
      checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);
      applyStimulus('{x: 5'h1B, y: 5'd3, lat: 1, prod: 10'h3F1, err: 1'b0});
      waitIdle(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
